// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter: one holding entry per requester,
// round-robin between different destinations, oldest-first for the same one.
module regfile_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqA,
  input  logic [4:0]  addrA,
  input  logic [31:0] dataA,
  output logic        readyA,
  input  logic        reqM,
  input  logic [4:0]  addrM,
  input  logic [31:0] dataM,
  output logic        readyM,
  output logic        WriteReg,
  output logic [4:0]  wAddr,
  output logic [31:0] wData,
  output logic [31:0] busy
);

  typedef enum logic {GRANT_A = 1'b0, GRANT_M = 1'b1} grant_e;

  logic        holdAValid_q, holdAValid_d;
  logic [4:0]  holdAAddr_q, holdAAddr_d;
  logic [31:0] holdAData_q, holdAData_d;
  logic        holdMValid_q, holdMValid_d;
  logic [4:0]  holdMAddr_q, holdMAddr_d;
  logic [31:0] holdMData_q, holdMData_d;
  grant_e      lastGrant_q, lastGrant_d;
  logic        ageAOlder_q, ageAOlder_d;
  logic        writeReg_q, writeReg_d;
  logic [4:0]  wAddr_q, wAddr_d;
  logic [31:0] wData_q, wData_d;
  logic [31:0] busy_q, busy_d;
  logic        grantA, grantM, loadA, loadM;

  // Same destination must drain oldest-first; otherwise alternate fairly.
  always_comb begin
    grantA = 1'b0;
    grantM = 1'b0;
    if (holdAValid_q && holdMValid_q) begin
      if (holdAAddr_q == holdMAddr_q) begin
        if (ageAOlder_q) grantA = 1'b1;
        else             grantM = 1'b1;
      end else if (lastGrant_q == GRANT_A) begin
        grantM = 1'b1;
      end else begin
        grantA = 1'b1;
      end
    end else if (holdAValid_q) begin
      grantA = 1'b1;
    end else if (holdMValid_q) begin
      grantM = 1'b1;
    end
  end

  assign readyA = !rst || !holdAValid_q || grantA;
  assign readyM = !rst || !holdMValid_q || grantM;
  assign loadA  = reqA && readyA && (addrA != 5'd0);
  assign loadM  = reqM && readyM && (addrM != 5'd0);

  always_comb begin
    holdAValid_d = holdAValid_q;
    holdAAddr_d  = holdAAddr_q;
    holdAData_d  = holdAData_q;
    holdMValid_d = holdMValid_q;
    holdMAddr_d  = holdMAddr_q;
    holdMData_d  = holdMData_q;
    lastGrant_d  = lastGrant_q;
    ageAOlder_d  = ageAOlder_q;
    writeReg_d   = grantA || grantM;
    wAddr_d      = wAddr_q;
    wData_d      = wData_q;
    busy_d       = '0;

    if (loadA) begin
      holdAValid_d = 1'b1;
      holdAAddr_d  = addrA;
      holdAData_d  = dataA;
    end else if (grantA) begin
      holdAValid_d = 1'b0;
    end
    if (loadM) begin
      holdMValid_d = 1'b1;
      holdMAddr_d  = addrM;
      holdMData_d  = dataM;
    end else if (grantM) begin
      holdMValid_d = 1'b0;
    end

    // A same-edge pair counts M as older, so a fresh A load always clears the bit.
    if (loadA)      ageAOlder_d = 1'b0;
    else if (loadM) ageAOlder_d = 1'b1;

    if (grantA) begin
      lastGrant_d = GRANT_A;
      wAddr_d     = holdAAddr_q;
      wData_d     = holdAData_q;
    end else if (grantM) begin
      lastGrant_d = GRANT_M;
      wAddr_d     = holdMAddr_q;
      wData_d     = holdMData_q;
    end

    if (holdAValid_d) busy_d = busy_d | (32'd1 << holdAAddr_d);
    if (holdMValid_d) busy_d = busy_d | (32'd1 << holdMAddr_d);
    if (writeReg_d)   busy_d = busy_d | (32'd1 << wAddr_d);
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      holdAValid_q <= 1'b0;
      holdAAddr_q  <= '0;
      holdAData_q  <= '0;
      holdMValid_q <= 1'b0;
      holdMAddr_q  <= '0;
      holdMData_q  <= '0;
      lastGrant_q  <= GRANT_A;
      ageAOlder_q  <= 1'b0;
      writeReg_q   <= 1'b0;
      wAddr_q      <= '0;
      wData_q      <= '0;
      busy_q       <= '0;
    end else begin
      holdAValid_q <= holdAValid_d;
      holdAAddr_q  <= holdAAddr_d;
      holdAData_q  <= holdAData_d;
      holdMValid_q <= holdMValid_d;
      holdMAddr_q  <= holdMAddr_d;
      holdMData_q  <= holdMData_d;
      lastGrant_q  <= lastGrant_d;
      ageAOlder_q  <= ageAOlder_d;
      writeReg_q   <= writeReg_d;
      wAddr_q      <= wAddr_d;
      wData_q      <= wData_d;
      busy_q       <= busy_d;
    end
  end

  assign WriteReg = writeReg_q;
  assign wAddr    = wAddr_q;
  assign wData    = wData_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table plus
// hand-written multi-cycle sequences, with a write-port scoreboard.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqA, reqM;
  logic [4:0]  addrA, addrM;
  logic [31:0] dataA, dataM;
  logic        readyA, readyM, WriteReg;
  logic [4:0]  wAddr;
  logic [31:0] wData, busy;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .reqA(reqA), .addrA(addrA), .dataA(dataA), .readyA(readyA),
    .reqM(reqM), .addrM(addrM), .dataM(dataM), .readyM(readyM),
    .WriteReg(WriteReg), .wAddr(wAddr), .wData(wData), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        reqA;
    logic [4:0]  addrA;
    logic [31:0] dataA;
    logic        reqM;
    logic [4:0]  addrM;
    logic [31:0] dataM;
    logic        expReadyA;
    logic        expReadyM;
    logic [31:0] expBusy;
  } vec_t;

  wr_t  expQ[$];
  int   nChecks = 0;
  int   nPass = 0;
  logic tbLastM = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Every observed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (WriteReg === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_write", 32'(WriteReg), 32'd0);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("write_addr", 32'(wAddr), 32'(e.addr));
        checkOutput("write_data", wData, e.data);
      end
    end
  end

  task automatic pushWrite(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic resetDut();
    reqA = 1'b0; reqM = 1'b0;
    addrA = '0; addrM = '0; dataA = '0; dataM = '0;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    tbLastM = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // One request pair from idle, then drain and confirm everything retired.
  task automatic applyStimulus(input vec_t v);
    logic wantA, wantM;
    reqA = v.reqA; addrA = v.addrA; dataA = v.dataA;
    reqM = v.reqM; addrM = v.addrM; dataM = v.dataM;
    @(negedge clk);
    checkOutput("vec_readyA", 32'(readyA), 32'(v.expReadyA));
    checkOutput("vec_readyM", 32'(readyM), 32'(v.expReadyM));
    wantA = v.reqA && (v.addrA != 5'd0);
    wantM = v.reqM && (v.addrM != 5'd0);
    if (wantA && wantM) begin
      if (v.addrA == v.addrM || !tbLastM) begin
        pushWrite(v.addrM, v.dataM);
        pushWrite(v.addrA, v.dataA);
        tbLastM = 1'b0;
      end else begin
        pushWrite(v.addrA, v.dataA);
        pushWrite(v.addrM, v.dataM);
        tbLastM = 1'b1;
      end
    end else if (wantA) begin
      pushWrite(v.addrA, v.dataA);
      tbLastM = 1'b0;
    end else if (wantM) begin
      pushWrite(v.addrM, v.dataM);
      tbLastM = 1'b1;
    end
    @(posedge clk);
    #1 reqA = 1'b0; reqM = 1'b0;
    @(negedge clk);
    checkOutput("vec_busy", busy, v.expBusy);
    waitCycles(4);
    @(negedge clk);
    checkOutput("vec_busy_clear", busy, 32'd0);
    checkOutput("vec_idle", 32'(WriteReg), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h0000_0020};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_1000};
    vecs[2] = '{1'b1, 5'd3,  32'h3333_0003, 1'b1, 5'd7,  32'h7777_0007, 1'b1, 1'b1, 32'h0000_0088};
    vecs[3] = '{1'b1, 5'd0,  32'h1111_1111, 1'b1, 5'd0,  32'h2222_2222, 1'b1, 1'b1, 32'h0000_0000};
    vecs[4] = '{1'b1, 5'd17, 32'h1700_0017, 1'b1, 5'd0,  32'h5555_5555, 1'b1, 1'b1, 32'h0002_0000};
    vecs[5] = '{1'b1, 5'd20, 32'hAAAA_0020, 1'b1, 5'd20, 32'hBBBB_0020, 1'b1, 1'b1, 32'h0010_0000};
    vecs[6] = '{1'b1, 5'd31, 32'hA31A_A31A, 1'b1, 5'd1,  32'hB01B_B01B, 1'b1, 1'b1, 32'h8000_0002};
    vecs[7] = '{1'b0, 5'd9,  32'h0,        1'b1, 5'd0,  32'h9999_9999, 1'b1, 1'b1, 32'h0000_0000};

    rst = 1'b0;
    reqA = 1'b0; reqM = 1'b0;
    addrA = '0; addrM = '0; dataA = '0; dataM = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_WriteReg", 32'(WriteReg), 32'd0);
    checkOutput("rst_wAddr", 32'(wAddr), 32'd0);
    checkOutput("rst_wData", wData, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    checkOutput("rst_readyA", 32'(readyA), 32'd1);
    checkOutput("rst_readyM", 32'(readyM), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    tbLastM = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Lone ALU write: exact two-cycle latency from acceptance.
    resetDut();
    reqA = 1'b1; addrA = 5'd5; dataA = 32'hDEADBEEF;
    @(negedge clk);
    pushWrite(5'd5, 32'hDEADBEEF);
    @(posedge clk);
    #1 reqA = 1'b0;
    @(negedge clk);
    checkOutput("lat_n1_WriteReg", 32'(WriteReg), 32'd0);
    checkOutput("lat_n1_busy", busy, 32'h0000_0020);
    @(negedge clk);
    checkOutput("lat_n2_WriteReg", 32'(WriteReg), 32'd1);
    checkOutput("lat_n2_busy", busy, 32'h0000_0020);
    @(negedge clk);
    checkOutput("lat_n3_busy", busy, 32'd0);
    @(posedge clk);
    #1;

    // Sustained contention: grants alternate M,A,M,A from reset.
    resetDut();
    reqA = 1'b1; addrA = 5'd3; reqM = 1'b1; addrM = 5'd7;
    for (int c = 0; c < 8; c++) begin
      logic eA, eM;
      dataA = 32'hA000_0000 + 32'(c);
      dataM = 32'hB000_0000 + 32'(c);
      eA = (c == 0) || (c % 2 == 0);
      eM = (c == 0) || (c % 2 == 1);
      @(negedge clk);
      checkOutput("cont_readyA", 32'(readyA), 32'(eA));
      checkOutput("cont_readyM", 32'(readyM), 32'(eM));
      if (eM) pushWrite(5'd7, dataM);
      if (eA) pushWrite(5'd3, dataA);
      @(posedge clk);
      #1;
    end
    reqA = 1'b0; reqM = 1'b0;
    waitCycles(5);
    @(negedge clk);
    checkOutput("cont_busy_clear", busy, 32'd0);
    @(posedge clk);
    #1;

    // Same address, M accepted one edge ahead of A.
    resetDut();
    reqM = 1'b1; addrM = 5'd9; dataM = 32'd1;
    @(negedge clk);
    checkOutput("order_readyM", 32'(readyM), 32'd1);
    pushWrite(5'd9, 32'd1);
    @(posedge clk);
    #1 reqM = 1'b0; reqA = 1'b1; addrA = 5'd9; dataA = 32'd2;
    @(negedge clk);
    checkOutput("order_readyA", 32'(readyA), 32'd1);
    pushWrite(5'd9, 32'd2);
    @(posedge clk);
    #1 reqA = 1'b0;
    waitCycles(4);

    // Same edge, same address, with round-robin favouring A: age must win.
    resetDut();
    applyStimulus('{1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h0000_0022, 1'b1, 1'b1, 32'h0000_0004});
    applyStimulus('{1'b1, 5'd4, 32'h0000_AAAA, 1'b1, 5'd4, 32'h0000_BBBB, 1'b1, 1'b1, 32'h0000_0010});

    // Reset mid-flight drops both held writes and any reset-cycle request.
    resetDut();
    reqA = 1'b1; addrA = 5'd10; dataA = 32'h1010_1010;
    reqM = 1'b1; addrM = 5'd11; dataM = 32'h1111_0000;
    @(posedge clk);
    #1 reqM = 1'b0; addrA = 5'd12; rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy_before", busy, 32'h0000_0C00);
    checkOutput("mid_readyA_rst", 32'(readyA), 32'd1);
    checkOutput("mid_readyM_rst", 32'(readyM), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1; reqA = 1'b0;
    @(negedge clk);
    checkOutput("mid_WriteReg", 32'(WriteReg), 32'd0);
    checkOutput("mid_busy", busy, 32'd0);
    waitCycles(4);
    @(negedge clk);
    checkOutput("mid_busy_late", busy, 32'd0);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
